bcd_event_counter: RTL and testbench
====================================

Name: bcd_event_counter

Overview:
- Multi-digit BCD up/down event counter in the MHzclk domain.
- Counts rising edges of the selected trigger, which is either the debounced button or the slow Hz tick.
- Presents packed BCD digits, 4 bits per digit, directly to the seven-segment scan driver; each nibble is 0–9 by construction.
- Replaces the plain binary counter, so the display shows decimal values without any downstream conversion.

Parameters:
- DIGITS, 4, number of BCD digits; count width = 4*DIGITS.
- START_UP, 1, count direction out of reset: 1 = up, 0 = down.

Ports:
- MHzclk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the MHzclk rising edge.
- trigger  input  1  level event input, synchronous to MHzclk; one count per rising edge.
- up_down  input  1  1 = increment, 0 = decrement; sampled on the edge that counts.
- clear  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_value  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0].
- count  output  4*DIGITS  packed BCD count; digit 0 (ones) in bits [3:0].
- wrap  output  1  one-cycle pulse when the count wraps (9999->0000 up, 0000->9999 down).
- edge_seen  output  1  one-cycle pulse on every accepted trigger rising edge.

Behaviour:
- Reset (reset==0 at a clock edge):
  - count = 0, wrap = 0, edge_seen = 0.
  - Internal trig_q = 1, so a trigger held high through reset release does not count.
  - Direction register = START_UP.
- Edge detect:
  - rise = trigger & ~trig_q; trig_q <= trigger on every edge.
  - A trigger high for N cycles counts exactly once.
  - Trigger pulses shorter than one clock are not guaranteed to be seen.
- Latency: count, edge_seen and wrap update on the same clock edge on which rise is true, i.e. the first edge where trigger=1 having been 0 at the previous edge. No further pipelining.
- Priority per edge: reset > clear > load > rise.
  - clear: count = 0; wrap = 0; edge_seen reflects rise.
  - load: each nibble of load_value > 9 is stored as 0, valid nibbles stored as given. wrap = 0; edge_seen reflects rise.
  - On a clear or load edge, the rise is consumed (trig_q still updates) and does not also count.
- Increment, ripple BCD:
  - Digit k increments when all lower digits are 9.
  - A digit at 9 that increments becomes 0.
  - All digits 9 -> all 0, with wrap = 1 for that cycle.
- Decrement:
  - Digit k decrements when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
  - All 0 -> all 9, with wrap = 1.
- Direction: up_down is captured only on counting edges. Changing direction between edges has no effect on count.
- Reset mid-operation: any edge with reset = 0 forces the reset state regardless of clear, load or trigger.
- Invariant: no nibble of count ever exceeds 9.
- wrap and edge_seen are registered outputs, high for exactly one cycle per event.
- Combinational logic is a DIGITS-wide generate chain of per-digit carry/borrow. No multi-cycle operations.

Test Plan:
- Reset then 12 trigger rising edges (each high 3 cycles), up_down = 1 -> count = 16'h0012; edge_seen pulses 12 times, one cycle each; wrap never asserted.
- Load 16'h9998, then 3 up edges -> count 9999, 0000 (wrap = 1 that cycle only), 0001.
- Load 16'h0001, then 3 down edges -> count 0000, 9999 (wrap = 1), 9998.
- Load 16'h0A5F -> count = 16'h0050 (invalid nibbles zeroed); then load and a trigger rise on the same edge -> load wins, no increment, edge_seen = 1.
- Trigger held high across reset deassertion -> count stays 0; trigger low then high -> count = 0001 on the first rising edge, with 1-cycle latency from the edge where trigger goes high.
- Count to 0042, assert reset = 0 for one edge concurrent with clear = 1 and a trigger rise -> count = 0, wrap = 0, edge_seen = 0; counting resumes correctly afterward.

Source files
------------

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD up/down event counter: counts rising edges of a trigger,
// with synchronous clear and parallel load of sanitized BCD digits.
module bcd_event_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          START_UP = 1'b1
) (
  input  logic                  MHzclk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic                  up_down,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  edge_seen
);

  localparam int unsigned W = 4 * DIGITS;

  logic          trig_q;
  logic          dir_q;
  logic          rise_c;
  logic          count_en_c;
  logic          dir_c;
  logic          wrap_c;
  logic [DIGITS:0] carry_c;
  logic [DIGITS:0] borrow_c;
  logic [W-1:0]  inc_c;
  logic [W-1:0]  dec_c;
  logic [W-1:0]  next_c;
  logic [W-1:0]  load_bcd_c;

  assign carry_c[0]  = 1'b1;
  assign borrow_c[0] = 1'b1;

  // Per-digit ripple: a digit steps only when every lower digit is at its limit.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] d;
    logic [3:0] lv;
    assign d  = count[4*k +: 4];
    assign lv = load_value[4*k +: 4];

    assign carry_c[k+1]  = carry_c[k]  & (d == 4'd9);
    assign borrow_c[k+1] = borrow_c[k] & (d == 4'd0);

    assign inc_c[4*k +: 4] = carry_c[k]  ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    assign dec_c[4*k +: 4] = borrow_c[k] ? ((d == 4'd0) ? 4'd9 : d - 4'd1) : d;

    assign load_bcd_c[4*k +: 4] = (lv > 4'd9) ? 4'd0 : lv;
  end

  // A rise on a clear or load edge is consumed without counting.
  always_comb begin
    rise_c     = trigger & ~trig_q;
    count_en_c = rise_c & ~clear & ~load;
    dir_c      = count_en_c ? up_down : dir_q;
    next_c     = dir_c ? inc_c : dec_c;
    wrap_c     = count_en_c & (dir_c ? carry_c[DIGITS] : borrow_c[DIGITS]);
  end

  always_ff @(posedge MHzclk) begin
    if (!reset) begin
      count     <= '0;
      wrap      <= 1'b0;
      edge_seen <= 1'b0;
      trig_q    <= 1'b1;
      dir_q     <= START_UP;
    end else begin
      trig_q    <= trigger;
      edge_seen <= rise_c;
      wrap      <= wrap_c;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_bcd_c;
      end else if (count_en_c) begin
        count <= next_c;
      end
      if (count_en_c) begin
        dir_q <= up_down;
      end
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench for bcd_event_counter: a decimal reference model predicts
// count/wrap/edge_seen for every cycle; a monitor compares after each edge.
module tb_bcd_event_counter;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          MODULO = 10000;

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         edge_seen;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         trigger;
  logic         up_down;
  logic         clear;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] count;
  logic         wrap;
  logic         edge_seen;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;
  int   cyc;

  // Reference model state, kept in plain decimal.
  int   m_val;
  logic m_prev;

  bcd_event_counter #(.DIGITS(DIGITS), .START_UP(1'b1)) dut (
    .MHzclk    (clk),
    .reset     (reset),
    .trigger   (trigger),
    .up_down   (up_down),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .wrap      (wrap),
    .edge_seen (edge_seen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    int v;
    int p;
    int nib;
    v = 0;
    p = 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib <= 9) v = v + nib * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic step(input logic r, input logic t, input logic ud,
                      input logic c, input logic l, input logic [W-1:0] lv);
    exp_t e;
    logic rise;
    @(negedge clk);
    reset = r; trigger = t; up_down = ud; clear = c; load = l; load_value = lv;
    e.wrap = 1'b0;
    if (!r) begin
      m_val = 0;
      m_prev = 1'b1;
      e.edge_seen = 1'b0;
    end else begin
      rise = t & ~m_prev;
      e.edge_seen = rise;
      if (c) m_val = 0;
      else if (l) m_val = from_load(lv);
      else if (rise) begin
        if (ud) begin
          e.wrap = (m_val == MODULO - 1);
          m_val = (m_val + 1) % MODULO;
        end else begin
          e.wrap = (m_val == 0);
          m_val = (m_val + MODULO - 1) % MODULO;
        end
      end
      m_prev = t;
    end
    e.count = to_bcd(m_val);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic t, input logic ud, input int n);
    for (int i = 0; i < n; i++) step(1'b1, t, ud, 1'b0, 1'b0, '0);
  endtask

  task automatic pulse(input logic ud, input int hi, input int lo);
    idle(1'b1, ud, hi);
    idle(1'b0, ud, lo);
  endtask

  task automatic do_load(input logic [W-1:0] lv);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, lv);
    idle(1'b0, 1'b1, 1);
  endtask

  // Monitor: one expected tuple per clock edge, compared after the edge.
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        n_checks++;
        if (count === e.count && wrap === e.wrap && edge_seen === e.edge_seen) begin
          n_pass++;
        end else begin
          $display("FAIL cycle %0d: count=%h wrap=%b edge_seen=%b, required count=%h wrap=%b edge_seen=%b",
                   cyc, count, wrap, edge_seen, e.count, e.wrap, e.edge_seen);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    int sel;
    n_checks = 0;
    n_pass = 0;
    m_val = 0;
    m_prev = 1'b1;
    reset = 1'b0; trigger = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0;
    load_value = '0;

    // Reset, then 12 up edges each high 3 cycles -> 0012.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) pulse(1'b1, 3, 1);

    // Up wrap from 9998.
    do_load(16'h9998);
    for (int i = 0; i < 3; i++) pulse(1'b1, 2, 1);

    // Down wrap from 0001.
    do_load(16'h0001);
    for (int i = 0; i < 3; i++) pulse(1'b0, 2, 1);

    // Invalid nibbles zeroed; load beats a simultaneous rise.
    do_load(16'h0A5F);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0A5F);
    idle(1'b1, 1'b1, 2);
    idle(1'b0, 1'b1, 1);

    // Trigger held high through reset release does not count.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(1'b1, 1'b1, 3);
    idle(1'b0, 1'b1, 1);
    idle(1'b1, 1'b1, 2);
    idle(1'b0, 1'b1, 1);

    // Count to 0042, then reset + clear + rise on one edge.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 42; i++) pulse(1'b1, 1, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) pulse(1'b1, 1, 1);

    // Clear with a rise: edge_seen still pulses, no count.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
    idle(1'b0, 1'b0, 1);
    pulse(1'b0, 1, 1);

    // Randomized traffic with boundary-heavy loads.
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9998;
        default: lv = W'($urandom);
      endcase
      step(($urandom_range(0, 63) != 0),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0),
           lv);
    end

    idle(1'b0, 1'b1, 2);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
